// File: rtl/process_launcher.sv
// Host-side launcher: delays after reset, runs the cores, reports done/timeout.
// Optional AUTO_RELAUNCH_EN: a finished (not timed-out) run re-arms by itself.
module process_launcher #(
  parameter int START_DELAY = 10,
  parameter int TIMEOUT     = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             fast_clock,
  input  logic             reset,
  input  logic             g1,
  input  logic             g2,
  input  logic             g3,
  input  logic             relaunch,
  output logic             start_process,
  output logic             busy,
  output logic             run_done,
  output logic             run_timeout,
  output logic [CNT_W-1:0] run_cycles,
  output logic [2:0]       core_status
);

  localparam int DW = $clog2(START_DELAY) + 1;
  localparam logic [DW-1:0] DLY_LAST =
    DW'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] RUN_LAST =
    CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_WAIT,
    S_RUN,
    S_DONE,
    S_TMO
  } state_t;

  state_t          state;
  logic [DW-1:0]   delay_cnt;
  logic            all_done;
  logic            rearm;
  logic [CNT_W-1:0] run_next;

  // Completion and counter helpers for the RUN state.
  always_comb begin
    all_done = g1 & g2 & g3;
    run_next = (run_cycles == CNT_MAX) ?
               run_cycles : run_cycles + 1'b1;
  end

  // Decide when a finished run goes back to the start delay.
  always_comb begin
    rearm = 1'b0;
    unique case (state)
      S_TMO:  rearm = relaunch;
`ifdef AUTO_RELAUNCH_EN
      S_DONE: rearm = 1'b1;
`else
      S_DONE: rearm = relaunch;
`endif
      default: rearm = 1'b0;
    endcase
  end

  // Launcher state machine with registered outputs.
  always_ff @(posedge fast_clock or posedge reset) begin
    if (reset) begin
      state         <= S_WAIT;
      delay_cnt     <= '0;
      start_process <= 1'b0;
      busy          <= 1'b1;
      run_done      <= 1'b0;
      run_timeout   <= 1'b0;
      run_cycles    <= '0;
      core_status   <= 3'b000;
    end else begin
      unique case (state)
        S_WAIT: begin
          if (delay_cnt == DLY_LAST) begin
            state         <= S_RUN;
            delay_cnt     <= '0;
            start_process <= 1'b1;
            run_cycles    <= '0;
          end else begin
            delay_cnt <= delay_cnt + 1'b1;
          end
        end
        S_RUN: begin
          run_cycles <= run_next;
          if (all_done) begin
            // completion beats a coincident timeout
            state         <= S_DONE;
            start_process <= 1'b0;
            busy          <= 1'b0;
            run_done      <= 1'b1;
            core_status   <= 3'b111;
          end else if (run_cycles == RUN_LAST) begin
            state         <= S_TMO;
            start_process <= 1'b0;
            busy          <= 1'b0;
            run_timeout   <= 1'b1;
            core_status   <= {g3, g2, g1};
          end
        end
        S_DONE, S_TMO: begin
          if (rearm) begin
            state       <= S_WAIT;
            delay_cnt   <= '0;
            busy        <= 1'b1;
            run_done    <= 1'b0;
            run_timeout <= 1'b0;
            run_cycles  <= '0;
          end
        end
        default: begin
          state <= S_WAIT;
        end
      endcase
    end
  end

endmodule
